// File: rtl/nic_vc_state_tracker_pkg.sv
// Shared definitions for the NIC VC state tracker.
//   N_OF_VC / N_OF_VN : virtual channels per virtual network / virtual networks
//   N_VC              : total tracked VCs (width of every per-VC vector)
//   vc_state_e        : per-VC lifecycle encoding
//   is_onehot()       : exactly-one-bit-set test on an N_VC-wide id
package nic_vc_state_tracker_pkg;

    localparam int N_OF_VC = 3;
    localparam int N_OF_VN = 2;
    localparam int N_VC    = N_OF_VC * N_OF_VN;

    typedef enum logic [1:0] {
        VC_IDLE   = 2'd0,
        VC_ALLOC  = 2'd1,
        VC_ACTIVE = 2'd2
    } vc_state_e;

    function automatic logic is_onehot(input logic [N_VC-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/nic_vc_state_tracker_if.sv
// Bundle between the NIC allocator / flit sender (master) and the VC state
// tracker (slave).
//   g_va_i / g_vc_id_i        : per-lane grant valid and one-hot granted VC
//   flit_sent_i / flit_vc_id_i / flit_is_tail_i : flit-send stream
//   credit_i                  : per-VC credit return pulses from the router
//   fifo_pointer_state_o      : per-VC busy vector back to the allocator
//   credit_avail_o            : per-VC credit > 0
//   error_o                   : sticky protocol-violation flag
interface nic_vc_state_tracker_if #(
    parameter int N_OF_REQUEST = 3,
    parameter int N_BITS_VC_ID = 6
);
    logic [N_OF_REQUEST-1:0]              g_va_i;
    logic [N_OF_REQUEST*N_BITS_VC_ID-1:0] g_vc_id_i;
    logic                                 flit_sent_i;
    logic [N_BITS_VC_ID-1:0]              flit_vc_id_i;
    logic                                 flit_is_tail_i;
    logic [N_BITS_VC_ID-1:0]              credit_i;
    logic [N_BITS_VC_ID-1:0]              fifo_pointer_state_o;
    logic [N_BITS_VC_ID-1:0]              credit_avail_o;
    logic                                 error_o;

    modport master (
        output g_va_i, g_vc_id_i, flit_sent_i, flit_vc_id_i, flit_is_tail_i, credit_i,
        input  fifo_pointer_state_o, credit_avail_o, error_o
    );

    modport slave (
        input  g_va_i, g_vc_id_i, flit_sent_i, flit_vc_id_i, flit_is_tail_i, credit_i,
        output fifo_pointer_state_o, credit_avail_o, error_o
    );
endinterface

// File: rtl/nic_vc_credit_counter.sv
// Saturating credit counter for one VC.
//   clk, rst     : clock, synchronous active-high reset (count -> BUFFER_DEPTH)
//   dec_i        : a flit was sent on this VC
//   inc_i        : router returned a credit for this VC
//   avail_o      : registered, count > 0
//   underflow_o  : combinational, this cycle's decrement would go below 0
//   overflow_o   : combinational, this cycle's increment would exceed BUFFER_DEPTH
module nic_vc_credit_counter #(
    parameter int BUFFER_DEPTH  = 4,
    parameter int N_BITS_CREDIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic dec_i,
    input  logic inc_i,
    output logic avail_o,
    output logic underflow_o,
    output logic overflow_o
);
    localparam logic [N_BITS_CREDIT-1:0] DEPTH = N_BITS_CREDIT'(BUFFER_DEPTH);

    logic [N_BITS_CREDIT-1:0] cnt_q, cnt_d;
    logic                     avail_q;

    // Simultaneous inc and dec cancel, so neither limit can be violated then.
    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = dec_i && !inc_i && (cnt_q == '0);
        overflow_o  = inc_i && !dec_i && (cnt_q == DEPTH);
        if (dec_i && !inc_i && !underflow_o)
            cnt_d = cnt_q - 1'b1;
        else if (inc_i && !dec_i && !overflow_o)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= DEPTH;
            avail_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            avail_q <= (cnt_d != '0);
        end
    end

    assign avail_o = avail_q;
endmodule

// File: rtl/nic_vc_state_tracker.sv
// Per-VC bookkeeping downstream of the NIC VC allocator. Tracks each VC through
// IDLE/ALLOC/ACTIVE from grants and the flit-send stream, keeps per-VC router
// credits, and feeds back registered busy / credit-available vectors.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of nic_vc_state_tracker_if (grants, flits, credits in;
//              busy, credit-avail, sticky error out)
module nic_vc_state_tracker
    import nic_vc_state_tracker_pkg::*;
#(
    parameter int N_OF_REQUEST  = 3,
    parameter int N_BITS_VC_ID  = N_VC,
    parameter int BUFFER_DEPTH  = 4,
    parameter int N_BITS_CREDIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    nic_vc_state_tracker_if.slave bus
);
    vc_state_e               state_q [N_BITS_VC_ID];
    logic [N_BITS_VC_ID-1:0] busy_q;
    logic                    error_q;

    logic [N_BITS_VC_ID-1:0] idle;
    logic [N_BITS_VC_ID-1:0] grant_hit, grant_dup;
    logic [N_BITS_VC_ID-1:0] flit_hit, flit_take;
    logic [N_BITS_VC_ID-1:0] underflow, overflow, avail;
    logic                    lane_bad, flit_vld, flit_bad, flit_idle_err;
    logic                    err_d;

    always_comb begin
        for (int v = 0; v < N_BITS_VC_ID; v++)
            idle[v] = (state_q[v] == VC_IDLE);
    end

    // OR-reduce valid one-hot grants across lanes; a VC already hit by an
    // earlier lane marks a duplicate. Malformed lanes are dropped entirely.
    always_comb begin
        grant_hit = '0;
        grant_dup = '0;
        lane_bad  = 1'b0;
        for (int k = 0; k < N_OF_REQUEST; k++) begin
            if (bus.g_va_i[k]) begin
                if (is_onehot(bus.g_vc_id_i[k*N_BITS_VC_ID +: N_BITS_VC_ID])) begin
                    grant_dup = grant_dup | (grant_hit & bus.g_vc_id_i[k*N_BITS_VC_ID +: N_BITS_VC_ID]);
                    grant_hit = grant_hit | bus.g_vc_id_i[k*N_BITS_VC_ID +: N_BITS_VC_ID];
                end else begin
                    lane_bad = 1'b1;
                end
            end
        end
    end

    // Flits count only on a well-formed id naming a non-IDLE VC; a flit that
    // would underflow the credit counter is dropped for the FSM too.
    assign flit_vld      = bus.flit_sent_i && is_onehot(bus.flit_vc_id_i);
    assign flit_bad      = bus.flit_sent_i && !is_onehot(bus.flit_vc_id_i);
    assign flit_hit      = flit_vld ? (bus.flit_vc_id_i & ~idle) : '0;
    assign flit_idle_err = flit_vld && ((bus.flit_vc_id_i & idle) != '0);
    assign flit_take     = flit_hit & ~underflow;

    for (genvar v = 0; v < N_BITS_VC_ID; v++) begin : g_cnt
        nic_vc_credit_counter #(
            .BUFFER_DEPTH  (BUFFER_DEPTH),
            .N_BITS_CREDIT (N_BITS_CREDIT)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .dec_i       (flit_hit[v]),
            .inc_i       (bus.credit_i[v]),
            .avail_o     (avail[v]),
            .underflow_o (underflow[v]),
            .overflow_o  (overflow[v])
        );
    end

    // A grant to a non-IDLE VC covers the grant+tail collision as well: the
    // grant is dropped and the tail proceeds through the FSM below.
    assign err_d = lane_bad || (grant_dup != '0) || ((grant_hit & ~idle) != '0) ||
                   flit_bad || flit_idle_err || (underflow != '0) || (overflow != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < N_BITS_VC_ID; v++) state_q[v] <= VC_IDLE;
            busy_q  <= '0;
            error_q <= 1'b0;
        end else begin
            error_q <= error_q || err_d;
            for (int v = 0; v < N_BITS_VC_ID; v++) begin
                case (state_q[v])
                    VC_IDLE: if (grant_hit[v]) begin
                        state_q[v] <= VC_ALLOC;
                        busy_q[v]  <= 1'b1;
                    end
                    VC_ALLOC: if (flit_take[v]) begin
                        state_q[v] <= bus.flit_is_tail_i ? VC_IDLE : VC_ACTIVE;
                        busy_q[v]  <= !bus.flit_is_tail_i;
                    end
                    VC_ACTIVE: if (flit_take[v] && bus.flit_is_tail_i) begin
                        state_q[v] <= VC_IDLE;
                        busy_q[v]  <= 1'b0;
                    end
                    default: begin
                        state_q[v] <= VC_IDLE;
                        busy_q[v]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.fifo_pointer_state_o = busy_q;
    assign bus.credit_avail_o       = avail;
    assign bus.error_o              = error_q;
endmodule

// File: tb/tb_nic_vc_state_tracker.sv
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a reference model that tracks only "VC busy" and an integer credit.
module tb_nic_vc_state_tracker;
    localparam int NR = 3;
    localparam int NV = 6;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nic_vc_state_tracker_if #(.N_OF_REQUEST(NR), .N_BITS_VC_ID(NV)) bus ();

    nic_vc_state_tracker #(
        .N_OF_REQUEST(NR), .N_BITS_VC_ID(NV), .BUFFER_DEPTH(DEPTH), .N_BITS_CREDIT(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model
    bit mbusy [NV];
    int mcred [NV];
    bit merr;

    function automatic int vc_idx(input logic [NV-1:0] id);
        for (int i = 0; i < NV; i++) if (id[i]) return i;
        return 0;
    endfunction

    function automatic logic [NV-1:0] exp_busy();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = mbusy[i];
        return r;
    endfunction

    function automatic logic [NV-1:0] exp_avail();
        logic [NV-1:0] r;
        for (int i = 0; i < NV; i++) r[i] = (mcred[i] > 0);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            mbusy[i] = 1'b0;
            mcred[i] = DEPTH;
        end
        merr = 1'b0;
    endfunction

    function automatic void model_step(input logic [NR-1:0] va, input logic [NR*NV-1:0] gid,
                                       input logic sent, input logic [NV-1:0] fvc,
                                       input logic tail, input logic [NV-1:0] cr);
        bit took [NV];
        bit acc  [NV];
        logic [NV-1:0] id;
        int v;
        for (int i = 0; i < NV; i++) begin took[i] = 0; acc[i] = 0; end
        for (int k = 0; k < NR; k++) begin
            if (va[k]) begin
                id = gid[k*NV +: NV];
                if ($countones(id) != 1) merr = 1;
                else begin
                    v = vc_idx(id);
                    if (took[v]) merr = 1;
                    else begin
                        took[v] = 1;
                        if (mbusy[v]) merr = 1;
                    end
                end
            end
        end
        if (sent) begin
            if ($countones(fvc) != 1) merr = 1;
            else begin
                v = vc_idx(fvc);
                if (!mbusy[v]) merr = 1;
                else if (mcred[v] == 0 && !cr[v]) merr = 1;
                else acc[v] = 1;
            end
        end
        for (int i = 0; i < NV; i++) begin
            if (cr[i] && !acc[i]) begin
                if (mcred[i] == DEPTH) merr = 1;
                else mcred[i]++;
            end
            if (acc[i] && !cr[i]) mcred[i]--;
            if (took[i] && !mbusy[i]) mbusy[i] = 1;
            else if (acc[i] && tail) mbusy[i] = 0;
        end
    endfunction

    task automatic check_all(input string tag);
        checks++;
        assert (bus.fifo_pointer_state_o === exp_busy()) else begin
            errors++;
            $error("FAIL %s busy: got %b expected %b", tag, bus.fifo_pointer_state_o, exp_busy());
        end
        checks++;
        assert (bus.credit_avail_o === exp_avail()) else begin
            errors++;
            $error("FAIL %s avail: got %b expected %b", tag, bus.credit_avail_o, exp_avail());
        end
        checks++;
        assert (bus.error_o === merr) else begin
            errors++;
            $error("FAIL %s error: got %b expected %b", tag, bus.error_o, merr);
        end
    endtask

    task automatic spot(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [NR-1:0] va, input logic [NR*NV-1:0] gid,
                       input logic sent, input logic [NV-1:0] fvc, input logic tail,
                       input logic [NV-1:0] cr);
        bus.g_va_i         = va;
        bus.g_vc_id_i      = gid;
        bus.flit_sent_i    = sent;
        bus.flit_vc_id_i   = fvc;
        bus.flit_is_tail_i = tail;
        bus.credit_i       = cr;
        model_step(va, gid, sent, fvc, tail, cr);
        @(posedge clk); #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic grant(input string tag, input int v);
        cyc(tag, 3'b001, (NR*NV)'(1) << v, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic flit(input string tag, input int v, input logic tail, input logic [NV-1:0] cr);
        cyc(tag, '0, '0, 1'b1, NV'(1) << v, tail, cr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.g_va_i = '0; bus.g_vc_id_i = '0; bus.flit_sent_i = 1'b0;
        bus.flit_vc_id_i = '0; bus.flit_is_tail_i = 1'b0; bus.credit_i = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all("reset");
    endtask

    initial begin
        logic [NR-1:0]    va;
        logic [NR*NV-1:0] gid;
        logic             sent, tail;
        logic [NV-1:0]    fvc, cr;
        int               v;

        // 1: reset and idle
        do_reset();
        for (int i = 0; i < 3; i++) idle("t1_idle");
        spot("t1_avail_all", &bus.credit_avail_o, 1'b1);

        // 2: head/body/tail on VC2
        do_reset();
        grant("t2_grant", 2);
        spot("t2_busy_after_grant", bus.fifo_pointer_state_o[2], 1'b1);
        flit("t2_head", 2, 1'b0, '0);
        flit("t2_body", 2, 1'b0, '0);
        spot("t2_busy_before_tail", bus.fifo_pointer_state_o[2], 1'b1);
        flit("t2_tail", 2, 1'b1, '0);
        spot("t2_busy_after_tail", bus.fifo_pointer_state_o[2], 1'b0);

        // 3: exhaust VC0 credit with single-flit packets, then underflow
        do_reset();
        for (int i = 0; i < 4; i++) begin
            grant("t3_grant", 0);
            flit("t3_single", 0, 1'b1, '0);
        end
        spot("t3_avail0_empty", bus.credit_avail_o[0], 1'b0);
        grant("t3_grant5", 0);
        flit("t3_underflow", 0, 1'b1, '0);
        spot("t3_err", bus.error_o, 1'b1);

        // 4: flit + credit cancel, then overflow at full
        do_reset();
        grant("t4_grant", 1);
        flit("t4_flit_cred", 1, 1'b0, 6'b000010);
        spot("t4_no_err", bus.error_o, 1'b0);
        cyc("t4_overflow", '0, '0, 1'b0, '0, 1'b0, 6'b000010);
        spot("t4_err", bus.error_o, 1'b1);

        // 5: duplicate grant, then grant to busy VC
        do_reset();
        cyc("t5_dup", 3'b011, {6'b0, 6'b010000, 6'b010000}, 1'b0, '0, 1'b0, '0);
        spot("t5_busy4", bus.fifo_pointer_state_o[4], 1'b1);
        do_reset();
        grant("t5_grant3", 3);
        grant("t5_regrant3", 3);
        spot("t5_busy3", bus.fifo_pointer_state_o[3], 1'b1);
        spot("t5_err", bus.error_o, 1'b1);

        // 6: reset mid-packet discards state
        do_reset();
        grant("t6_grant", 5);
        flit("t6_head", 5, 1'b0, '0);
        flit("t6_body", 5, 1'b0, '0);
        cyc("t6_bad_flit", '0, '0, 1'b1, 6'b110000, 1'b0, '0);
        do_reset();
        spot("t6_busy5", bus.fifo_pointer_state_o[5], 1'b0);
        grant("t6_regrant", 5);
        for (int i = 0; i < 4; i++) flit("t6_drain", 5, 1'b0, '0);
        spot("t6_avail5_after4", bus.credit_avail_o[5], 1'b0);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            va  = '0;
            gid = (NR*NV)'({$urandom, $urandom});
            for (int k = 0; k < NR; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    va[k] = 1'b1;
                    if ($urandom_range(0, 15) == 0) gid[k*NV +: NV] = NV'($urandom);
                    else gid[k*NV +: NV] = NV'(1) << $urandom_range(0, NV-1);
                end
            end
            sent = ($urandom_range(0, 1) == 1);
            v    = $urandom_range(0, NV-1);
            fvc  = ($urandom_range(0, 31) == 0) ? NV'($urandom) : (NV'(1) << v);
            tail = ($urandom_range(0, 2) == 0);
            cr   = '0;
            for (int j = 0; j < NV; j++)
                cr[j] = ((mcred[j] < DEPTH) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 49) == 0);
            // keep flit+credit on an empty VC out of the random mix
            if (sent && $countones(fvc) == 1 && mcred[vc_idx(fvc)] == 0) cr[vc_idx(fvc)] = 1'b0;
            cyc("rand", va, gid, sent, fvc, tail, cr);
            if (i % 50 == 49) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
